// File: rtl/membrane_keypad_emulator_pkg.sv
// Purpose: key codes, FSM states and key-to-matrix mapping for the keypad emulator.
// Latency: combinational helpers only.
// Backpressure: n/a.
package safe_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    // d selects the scanner drive line, s the sense line the switch connects to
    typedef struct packed {
        logic       valid;
        logic [1:0] d;
        logic [1:0] s;
    } key_map_t;

    function automatic key_map_t map_key(input logic [3:0] code);
        key_map_t m;
        m = '{valid: 1'b0, d: 2'd0, s: 2'd0};
        case (code)
            4'd1:     m = '{valid: 1'b1, d: 2'd0, s: 2'd0};
            4'd2:     m = '{valid: 1'b1, d: 2'd1, s: 2'd0};
            4'd3:     m = '{valid: 1'b1, d: 2'd2, s: 2'd0};
            4'd4:     m = '{valid: 1'b1, d: 2'd0, s: 2'd1};
            4'd5:     m = '{valid: 1'b1, d: 2'd1, s: 2'd1};
            4'd6:     m = '{valid: 1'b1, d: 2'd2, s: 2'd1};
            4'd7:     m = '{valid: 1'b1, d: 2'd0, s: 2'd2};
            4'd8:     m = '{valid: 1'b1, d: 2'd1, s: 2'd2};
            4'd9:     m = '{valid: 1'b1, d: 2'd2, s: 2'd2};
            4'd0:     m = '{valid: 1'b1, d: 2'd1, s: 2'd3};
            KEY_STAR: m = '{valid: 1'b1, d: 2'd0, s: 2'd3};
            KEY_HASH: m = '{valid: 1'b1, d: 2'd2, s: 2'd3};
            default:  m = '{valid: 1'b0, d: 2'd0, s: 2'd0};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/membrane_keypad_emulator_if.sv
// Purpose: key-press request channel (valid/ready plus 4-bit key code).
// Latency: wires only.
// Backpressure: key_ready low while a press or gap is running.
interface membrane_keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/membrane_keypad_emulator_bounce_lfsr.sv
// Purpose: free-running 16-bit Galois LFSR (taps 16,14,13,11) supplying contact chatter; built only with KEYPAD_BOUNCE_EN.
// Latency: new bit every clk.
// Backpressure: none.
`ifdef KEYPAD_BOUNCE_EN
module bounce_lfsr (
    input  logic clk,
    input  logic rst_n,
    output logic chatter
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign chatter = lfsr_q[0];

endmodule
`endif

// File: rtl/membrane_keypad_emulator.sv
// Purpose: 4x3 membrane keypad model; holds a requested key for HOLD_CYCLES then releases for GAP_CYCLES (KEYPAD_BOUNCE_EN adds contact chatter).
// Latency: sense follows drive one clk later; request to next ready is HOLD_CYCLES + GAP_CYCLES clks.
// Backpressure: key_ready only in IDLE; requests during press/gap wait.
module membrane_keypad_emulator
    import safe_pkg::*;
#(
    parameter int HOLD_CYCLES = 4096,
    parameter int GAP_CYCLES  = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    membrane_keypad_emulator_if.slave   key_if,
    input  logic [2:0]                  drive,
    output logic [3:0]                  sense,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       d_q, d_nxt, s_q, s_nxt;
    logic [3:0]       sense_nxt;
    logic             done_nxt, err_nxt;
    logic             ready, xfer;
    logic             contact, chatter_win;
    key_map_t         req_map;

    assign req_map          = map_key(key_if.key_code);
    assign ready            = (state_q == IDLE);
    assign key_if.key_ready = ready;
    assign xfer             = key_if.key_valid && ready;
    assign busy             = (state_q != IDLE);

`ifdef KEYPAD_BOUNCE_EN
    logic       chatter;
    logic [3:0] age_q;

    bounce_lfsr u_bounce_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .chatter (chatter)
    );

    // Cycles spent in the current phase, saturating once the chatter window is over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (state_nxt != state_q) begin
            age_q <= '0;
        end else if (age_q != 4'd8) begin
            age_q <= age_q + 4'd1;
        end
    end

    assign chatter_win = (state_q != IDLE) && (age_q < 4'd8);
    assign contact     = drive[d_q] & (chatter_win ? chatter : 1'b1);
`else
    assign chatter_win = 1'b0;
    assign contact     = drive[d_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            s_q     <= '0;
            sense   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            d_q     <= d_nxt;
            s_q     <= s_nxt;
            sense   <= sense_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        d_nxt     = d_q;
        s_nxt     = s_q;
        sense_nxt = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (req_map.valid) begin
                        state_nxt = PRESS;
                        cnt_nxt   = HOLD_LD;
                        d_nxt     = req_map.d;
                        s_nxt     = req_map.s;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PRESS: begin
                // Only the latched drive line reaches the sense line: no ghosting
                sense_nxt[s_q] = contact;
                if (cnt_q == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                sense_nxt[s_q] = contact & chatter_win;
                if (cnt_q == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_membrane_keypad_emulator.sv
// Bench for membrane_keypad_emulator (clean-contact build): table vectors, corner sequences
// and random traffic checked against a timeline model of press/gap windows.
module tb_membrane_keypad_emulator;

    localparam int H      = 5;
    localparam int G      = 3;
    localparam int IDLE_T = 1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] drive = 3'b000;
    logic [3:0] sense;
    logic       busy, done, err;

    membrane_keypad_emulator_if key_if();

    membrane_keypad_emulator #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_if (key_if),
        .drive  (drive),
        .sense  (sense),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: t_m = clk edges since the last accepted valid key (IDLE_T = long idle)
    int         t_m = IDLE_T;
    int         m_d = 0;
    int         m_s = 0;
    bit         m_err = 1'b0;
    logic [2:0] drv_edge = 3'b000;

    typedef struct {
        logic [3:0] code;
        logic [2:0] drv;
        logic [3:0] exp_sense;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_map(input logic [3:0] k, output bit v, output int d, output int s);
        int ki;
        ki = int'(k);
        v = 1'b1;
        d = 0;
        s = 0;
        if (ki >= 1 && ki <= 9) begin
            d = (ki - 1) % 3;
            s = (ki - 1) / 3;
        end else if (ki == 0) begin
            d = 1; s = 3;
        end else if (ki == 10) begin
            d = 0; s = 3;
        end else if (ki == 11) begin
            d = 2; s = 3;
        end else begin
            v = 1'b0;
        end
    endfunction

    // One clock: update the model at the edge, compare every output on the falling edge
    task automatic step();
        bit         v, idle;
        int         d, s;
        logic [3:0] exp_sense;
        @(posedge clk);
        idle     = (t_m >= H + G);
        drv_edge = drive;
        m_err    = 1'b0;
        model_map(key_if.key_code, v, d, s);
        if (key_if.key_valid && idle && v) begin
            t_m = 0;
            m_d = d;
            m_s = s;
        end else begin
            if (key_if.key_valid && idle) m_err = 1'b1;
            if (t_m < IDLE_T) t_m++;
        end
        @(negedge clk);
        exp_sense = 4'b0000;
        if (t_m >= 1 && t_m <= H && drv_edge[m_d]) exp_sense = 4'b0001 << m_s;
        check("sense", 32'(sense), 32'(exp_sense));
        check("busy", 32'(busy), 32'(t_m < H + G));
        check("key_ready", 32'(key_if.key_ready), 32'(t_m >= H + G));
        check("done", 32'(done), 32'(t_m == H + G));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic run_vec(input vec_t vc);
        key_if.key_valid = 1'b1;
        key_if.key_code  = vc.code;
        drive            = vc.drv;
        step();
        key_if.key_valid = 1'b0;
        check("tbl_err", 32'(err), 32'(vc.exp_err));
        for (int i = 1; i <= H + G + 1; i++) begin
            step();
            if (i <= H) check("tbl_sense", 32'(sense), 32'(vc.exp_sense));
        end
    endtask

    initial begin
        int rdy_at;
        int n_done;

        vecs[0] = '{code: 4'd5,  drv: 3'b010, exp_sense: 4'b0010, exp_err: 1'b0};
        vecs[1] = '{code: 4'd0,  drv: 3'b111, exp_sense: 4'b1000, exp_err: 1'b0};
        vecs[2] = '{code: 4'd10, drv: 3'b111, exp_sense: 4'b1000, exp_err: 1'b0};
        vecs[3] = '{code: 4'd11, drv: 3'b111, exp_sense: 4'b1000, exp_err: 1'b0};
        vecs[4] = '{code: 4'd1,  drv: 3'b001, exp_sense: 4'b0001, exp_err: 1'b0};
        vecs[5] = '{code: 4'd9,  drv: 3'b100, exp_sense: 4'b0100, exp_err: 1'b0};
        vecs[6] = '{code: 4'd5,  drv: 3'b101, exp_sense: 4'b0000, exp_err: 1'b0};
        vecs[7] = '{code: 4'd8,  drv: 3'b111, exp_sense: 4'b0100, exp_err: 1'b0};
        vecs[8] = '{code: 4'd13, drv: 3'b111, exp_sense: 4'b0000, exp_err: 1'b1};

        key_if.key_valid = 1'b0;
        key_if.key_code  = 4'd0;

        // Reset state
        #12;
        check("rst_sense", 32'(sense), 32'd0);
        check("rst_ready", 32'(key_if.key_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with scanning drive: nothing pressed
        for (int i = 0; i < 6; i++) begin
            drive = 3'b001 << (i % 3);
            step();
        end

        // Key 5 under a one-hot scan
        key_if.key_valid = 1'b1;
        key_if.key_code  = 4'd5;
        drive            = 3'b001;
        step();
        key_if.key_valid = 1'b0;
        rdy_at = -1;
        n_done = 0;
        for (int i = 1; i <= H + G + 2; i++) begin
            drive = 3'b001 << (i % 3);
            step();
            if (key_if.key_ready && rdy_at < 0) rdy_at = i;
            if (done) n_done++;
        end
        check("k5_ready_lat", 32'(rdy_at), 32'(H + G));
        check("k5_done_count", 32'(n_done), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: key 1 then key 2 with valid held
        drive            = 3'b011;
        key_if.key_valid = 1'b1;
        key_if.key_code  = 4'd1;
        step();
        key_if.key_code = 4'd2;
        for (int i = 1; i <= H + G + 1; i++) begin
            step();
            if (i == H + G) check("b2b_ready_on_done", 32'({key_if.key_ready, done}), 32'b11);
            if (i == H + G + 1) check("b2b_second_accepted", 32'(busy), 32'd1);
        end
        key_if.key_valid = 1'b0;
        n_done = 0;
        for (int i = 0; i < H + G + 1; i++) begin
            step();
            if (done) n_done++;
        end
        check("b2b_second_done", 32'(n_done), 32'd1);

        // Reset in the middle of a press of key 9
        drive            = 3'b100;
        key_if.key_valid = 1'b1;
        key_if.key_code  = 4'd9;
        step();
        key_if.key_valid = 1'b0;
        step();
        step();
        check("mid_press_sense", 32'(sense), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sense", 32'(sense), 32'd0);
        check("arst_ready", 32'(key_if.key_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        t_m = IDLE_T;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < H + G + 2; i++) begin
            step();
            if (done) n_done++;
        end
        check("arst_no_done", 32'(n_done), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            key_if.key_valid = ($urandom_range(0, 3) == 0);
            key_if.key_code  = 4'($urandom_range(0, 15));
            drive            = 3'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
